// File: rtl/ramb_s4_stream_reader_pkg.sv
// Shared constants and types for the 4-bit block RAM stream reader.
// Defining RAMB_S4_READER_PARITY_EN widens the output nibble by one even-parity bit.
package ramb_s4_rd_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 4;
    localparam int LEN_W   = 13;
    localparam int MAX_LEN = 4096;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    function automatic int out_w();
`ifdef RAMB_S4_READER_PARITY_EN
        return DATA_W + 1;
`else
        return DATA_W;
`endif
    endfunction

    localparam int OUT_W = out_w();

endpackage

// File: rtl/ramb_s4_skid_buf.sv
// Two-entry valid/ready output buffer carrying a LAST sideband bit.
// Data and LAST read as zero whenever the buffer is empty.
module ramb_s4_skid_buf
    import ramb_s4_rd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic [1:0]        count_o
);

    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       pop_ok;

    assign pop_ok = pop_i && (count_q != 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ent
            logic [DATA_W-1:0] data_q;
            logic              last_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    data_q <= '0;
                    last_q <= 1'b0;
                end else if (push_i && (wr_ptr_q == 1'(gi))) begin
                    data_q <= push_data_i;
                    last_q <= push_last_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid_o = (count_q != 2'd0);
    assign count_o     = count_q;

    always_comb begin
        out_data_o = '0;
        out_last_o = 1'b0;
        if (out_valid_o) begin
            out_data_o = rd_ptr_q ? g_ent[1].data_q : g_ent[0].data_q;
            out_last_o = rd_ptr_q ? g_ent[1].last_q : g_ent[0].last_q;
        end
    end

endmodule

// File: rtl/ramb_s4_stream_reader.sv
// Burst read initiator for the x4 port of the asymmetric block RAM, streaming nibbles out.
// Defining RAMB_S4_READER_PARITY_EN appends an even-parity MSB to each output nibble.
module ramb_s4_stream_reader
    import ramb_s4_rd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_do_i,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic [OUT_W-1:0]  dout_data_o,
    output logic              dout_last_o,
    output logic              busy_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr_q;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              rd_vld_q, rd_last_q;

    logic              issue, issue_last, pop, credit_ok;
    logic [LEN_W-1:0]  len_eff;
    logic [1:0]        occ;
    logic              buf_valid, buf_last;
    logic [DATA_W-1:0] buf_data;
    logic [1:0]        buf_count;

    assign len_eff = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;
    assign pop     = buf_valid && dout_ready_i;

    // Occupancy = nibble on the RAM bus plus buffered; a same-cycle pop frees a slot.
    assign occ       = buf_count + {1'b0, rd_vld_q};
    assign credit_ok = pop ? (occ < 2'd3) : (occ < 2'd2);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i;
                    rem_d  = len_eff;
                    if (len_eff != '0) state_d = READ;
                end
            end
            READ: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && buf_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rem_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            rd_vld_q  <= issue;
            rd_last_q <= issue_last;
            if (issue) last_addr_q <= addr_q;
        end
    end

    ramb_s4_skid_buf u_buf (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (rd_vld_q),
        .push_data_i (ram_do_i),
        .push_last_i (rd_last_q),
        .pop_i       (pop),
        .out_valid_o (buf_valid),
        .out_data_o  (buf_data),
        .out_last_o  (buf_last),
        .count_o     (buf_count)
    );

    assign cmd_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign ram_en_o     = issue;
    assign ram_addr_o   = issue ? addr_q : last_addr_q;
    assign dout_valid_o = buf_valid;
    assign dout_last_o  = buf_last;

`ifdef RAMB_S4_READER_PARITY_EN
    assign dout_data_o = {^buf_data, buf_data};
`else
    assign dout_data_o = buf_data;
`endif

endmodule

// File: tb/tb_ramb_s4_stream_reader.sv
// Self-checking bench: queue-based model of burst output plus directed literal checks.
module tb_ramb_s4_stream_reader;
    import ramb_s4_rd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr, ram_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              ram_en, dout_valid, dout_ready, dout_last, busy;
    logic [DATA_W-1:0] ram_do;
    logic [OUT_W-1:0]  dout_data;
    bit                tog_en;

    logic [DATA_W-1:0] mem [4096];

    ramb_s4_stream_reader dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .ram_en_o     (ram_en),
        .ram_addr_o   (ram_addr),
        .ram_do_i     (ram_do),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .dout_data_o  (dout_data),
        .dout_last_o  (dout_last),
        .busy_o       (busy)
    );

    // RAM B-port: registered read, one cycle latency
    always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] fmt(input logic [DATA_W-1:0] n);
`ifdef RAMB_S4_READER_PARITY_EN
        return {^n, n};
`else
        return n;
`endif
    endfunction

    // Model state and observation logs
    logic [OUT_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    bit                exp_busy;
    int                issued, popped, last_cnt, cyc, acc_cyc, first_valid_cyc, busy_cycles;
    logic [OUT_W-1:0]  out_log[$];
    logic [ADDR_W-1:0] addr_log[$];
    int                last_idx[$];
    int                valid_cyc[$];
    bit                prev_hold;
    logic [OUT_W-1:0]  prev_data;
    logic              prev_last;

    always @(negedge clk) begin
        bit               was_busy;
        int               len_e;
        logic [ADDR_W-1:0] a;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            exp_addr_q.delete();
            exp_busy  = 1'b0;
            prev_hold = 1'b0;
            issued    = 0;
            popped    = 0;
        end else begin
            was_busy = exp_busy;
            chk("cmd_ready", 32'(cmd_ready), 32'(!was_busy));
            chk("busy", 32'(busy), 32'(was_busy));
            if (busy) busy_cycles++;
            if (prev_hold) begin
                chk("hold_valid", 32'(dout_valid), 32'd1);
                chk("hold_data", 32'(dout_data), 32'(prev_data));
                chk("hold_last", 32'(dout_last), 32'(prev_last));
            end
            if (ram_en) begin
                issued++;
                addr_log.push_back(ram_addr);
                chk("ram_en_expected", 32'(exp_addr_q.size() > 0), 32'd1);
                if (exp_addr_q.size() > 0) chk("ram_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
            end
            if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (!dout_valid) chk("last_without_valid", 32'(dout_last), 32'd0);
            if (dout_valid && dout_ready) begin
                popped++;
                valid_cyc.push_back(cyc);
                out_log.push_back(dout_data);
                if (dout_last) begin
                    last_cnt++;
                    last_idx.push_back(out_log.size() - 1);
                end
                chk("dout_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("dout_data", 32'(dout_data), 32'(exp_q.pop_front()));
                    chk("dout_last", 32'(dout_last), 32'(exp_q.size() == 0));
                    if (exp_q.size() == 0) exp_busy = 1'b0;
                end
            end
            chk("outstanding_le2", 32'((issued - popped) <= 2), 32'd1);
            prev_hold = dout_valid && !dout_ready;
            prev_data = dout_data;
            prev_last = dout_last;
            if (cmd_valid && !was_busy) begin
                acc_cyc = cyc;
                first_valid_cyc = -1;
                len_e = (cmd_len > 13'd4096) ? 4096 : int'(cmd_len);
                for (int i = 0; i < len_e; i++) begin
                    a = ADDR_W'(int'(cmd_addr) + i);
                    exp_addr_q.push_back(a);
                    exp_q.push_back(fmt(mem[a]));
                end
                exp_busy = (len_e != 0);
            end
        end
    end

    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout_ready = tog_en ? ~dout_ready : 1'b1;
        end
    end

    task automatic clear_logs();
        out_log.delete();
        addr_log.delete();
        last_idx.delete();
        valid_cyc.delete();
        last_cnt    = 0;
        busy_cycles = 0;
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        clear_logs();
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("cmd addr=%03h len=%0d issued", a, l);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || dout_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
        @(posedge clk);
        #1;
        $display("burst done: %0d nibbles, %0d last flags", out_log.size(), last_cnt);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_dout_data"}, 32'(dout_data), 32'd0);
        chk({tag, "_dout_last"}, 32'(dout_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int iss0;
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        tog_en = 1'b0;
        first_valid_cyc = -1;
        for (int a = 0; a < 4096; a++) mem[a] = 4'((a * 7) + (a >> 5));
        mem[12'h010] = 4'h1; mem[12'h011] = 4'h2; mem[12'h012] = 4'h3; mem[12'h013] = 4'h4;
        mem[12'h020] = 4'h7; mem[12'h021] = 4'h3;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // Basic burst, sink always ready
        start_burst(12'h010, 13'd4);
        wait_idle(50);
        chk("t1_count", 32'(out_log.size()), 32'd4);
        if (out_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t1_data", 32'(out_log[i][DATA_W-1:0]), 32'(i + 1));
            chk("t1_consecutive", 32'(valid_cyc[3] - valid_cyc[0]), 32'd3);
        end
        chk("t1_last_cnt", 32'(last_cnt), 32'd1);
        if (last_idx.size() > 0) chk("t1_last_idx", 32'(last_idx[0]), 32'd3);
        chk("t1_first_valid_lat", 32'(first_valid_cyc - acc_cyc), 32'd3);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd6);

        // Address wrap
        start_burst(12'hFFE, 13'd4);
        wait_idle(50);
        chk("t2_addr_cnt", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk("t2_addr0", 32'(addr_log[0]), 32'hFFE);
            chk("t2_addr1", 32'(addr_log[1]), 32'hFFF);
            chk("t2_addr2", 32'(addr_log[2]), 32'h000);
            chk("t2_addr3", 32'(addr_log[3]), 32'h001);
        end
        if (last_idx.size() > 0) chk("t2_last_idx", 32'(last_idx[0]), 32'd3);

        // Toggling sink with a stray command while busy
        tog_en = 1'b1;
        start_burst(12'h040, 13'd8);
        repeat (3) @(posedge clk);
        #1;
        cmd_addr = 12'h300; cmd_len = 13'd5; cmd_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle(100);
        tog_en = 1'b0;
        chk("t3_count", 32'(out_log.size()), 32'd8);
        chk("t3_last_cnt", 32'(last_cnt), 32'd1);

        // Zero-length command
        iss0 = issued;
        start_burst(12'h123, 13'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_no_reads", 32'(issued - iss0), 32'd0);
        chk("t4_no_output", 32'(out_log.size()), 32'd0);
        chk("t4_no_busy", 32'(busy_cycles), 32'd0);

        // Full-size burst and clamped oversize burst
        start_burst(12'h000, 13'd4096);
        wait_idle(5000);
        chk("t5_count", 32'(out_log.size()), 32'd4096);
        chk("t5_last_cnt", 32'(last_cnt), 32'd1);
        if (last_idx.size() > 0) chk("t5_last_idx", 32'(last_idx[0]), 32'd4095);
        if (addr_log.size() == 4096) chk("t5_final_addr", 32'(addr_log[4095]), 32'hFFF);
        start_burst(12'h800, 13'h1FFF);
        wait_idle(5000);
        chk("t5_clamp_count", 32'(out_log.size()), 32'd4096);
        chk("t5_clamp_last_cnt", 32'(last_cnt), 32'd1);

        // Reset while the third nibble is presented
        start_burst(12'h100, 13'd10);
        n = 0;
        while (!(dout_valid && out_log.size() == 2) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_reach_third", 32'(n < 50), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_burst(12'h010, 13'd4);
        wait_idle(50);
        chk("t6_count", 32'(out_log.size()), 32'd4);
        if (out_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("t6_data", 32'(out_log[i][DATA_W-1:0]), 32'(i + 1));
        chk("t6_last_cnt", 32'(last_cnt), 32'd1);

        // Output formatting of 0x7 and 0x3
        start_burst(12'h020, 13'd2);
        wait_idle(50);
        chk("t7_count", 32'(out_log.size()), 32'd2);
        if (out_log.size() == 2) begin
`ifdef RAMB_S4_READER_PARITY_EN
            chk("t7_nib7", 32'(out_log[0]), 32'h17);
            chk("t7_nib3", 32'(out_log[1]), 32'h03);
`else
            chk("t7_nib7", 32'(out_log[0]), 32'h7);
            chk("t7_nib3", 32'(out_log[1]), 32'h3);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
